branch_resolver: RTL

Initiator-side companion to the 2-bit saturating branch predictor. Issues prediction requests for fetched branches. Holds each returned prediction in an in-order in-flight queue until the branch resolves. Returns the actual outcome to the predictor as a one-cycle `result`/`taken` update, and flags mispredictions to the front end with a flush. Sits between fetch/execute and the predictor; it is the only driver of the predictor's `request`, `result` and `taken` inputs.

---
 rtl/branch_resolver_if.sv | 14 +
 rtl/branch_resolver.sv | 62 ++++++
 2 files changed

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: resolver<->front-end/predictor signal bundle; master = resolver (drives request/result/taken/stall/mispredict/flush/resolve_err/counters), slave = environment (drives fetch_branch/resolve_valid/resolve_taken/prediction)
interface branch_resolver_if #(parameter int CNT_W = 16);
  logic fetch_branch, resolve_valid, resolve_taken, prediction;
  logic request, result, taken, stall, mispredict, flush, resolve_err;
  logic [CNT_W-1:0] branch_count, miss_count;
  modport master(
    input  fetch_branch, resolve_valid, resolve_taken, prediction,
    output request, result, taken, stall, mispredict, flush, resolve_err, branch_count, miss_count
  );
  modport slave(
    output fetch_branch, resolve_valid, resolve_taken, prediction,
    input  request, result, taken, stall, mispredict, flush, resolve_err, branch_count, miss_count
  );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: issues predictor requests, queues predictions in order, returns outcomes as result/taken and flushes on mispredict; ports clk, rst, bus (branch_resolver_if.master)
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  branch_resolver_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] q;
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] count;
  logic cap_pend, empty, pop, bypass, resolve, head, kill, capture;
  logic result_q, taken_q, miss_q, err_q;
  logic [CNT_W-1:0] branch_q, miss_cnt_q;
  always_comb begin
    empty = count == '0;
    pop = bus.resolve_valid & ~empty;
    bypass = bus.resolve_valid & empty & cap_pend;
    resolve = pop | bypass;
    head = pop ? q[rptr] : bus.prediction;
    kill = resolve & (head != bus.resolve_taken);
    capture = cap_pend & ~kill & ~bypass;
    bus.stall = (count == (AW+1)'(DEPTH)) | ((count == (AW+1)'(DEPTH-1)) & cap_pend);
    bus.request = bus.fetch_branch & ~bus.stall & ~rst & ~kill;
  end
  always_ff @(posedge clk)
    if (capture) q[wptr] <= bus.prediction;
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      cap_pend <= 1'b0;
      result_q <= 1'b0;
      taken_q <= 1'b0;
      miss_q <= 1'b0;
      err_q <= 1'b0;
      branch_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      cap_pend <= bus.request;
      rptr <= kill ? '0 : rptr + AW'(pop);
      wptr <= kill ? '0 : wptr + AW'(capture);
      count <= kill ? '0 : count + (AW+1)'(capture) - (AW+1)'(pop);
      result_q <= resolve;
      taken_q <= resolve & bus.resolve_taken;
      miss_q <= kill;
      err_q <= bus.resolve_valid & empty & ~cap_pend;
      if (resolve && !(&branch_q)) branch_q <= branch_q + CNT_W'(1);
      if (kill && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end
  assign bus.result = result_q;
  assign bus.taken = taken_q;
  assign bus.mispredict = miss_q;
  assign bus.flush = miss_q;
  assign bus.resolve_err = err_q;
  assign bus.branch_count = branch_q;
  assign bus.miss_count = miss_cnt_q;
endmodule
